bip_debug_unit: RTL

BIP_DEBUG_UNIT -- requirements
Module: bip_debug_unit

---
 rtl/bip_debug_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bip_debug_unit.sv
// UART-driven debug unit: loads program/data memory, reads data memory back,
// and runs the processor for a fixed number of clock-enable cycles.
module bip_debug_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 11,
    parameter int RUN_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              wr_pm,
    output logic              wr_dm,
    output logic              rd_dm,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_reset,
    output logic              cpu_en,
    output logic              busy
);
    localparam int NB  = DATA_W / 8;
    localparam int NA  = (ADDR_W + 7) / 8;
    localparam int AW8 = NA * 8;
    localparam logic [2:0]  NB_LAST  = 3'(NB - 1);
    localparam logic [2:0]  NA_LAST  = 3'(NA - 1);
    localparam logic [15:0] CYC_LAST = 16'(RUN_CYCLES - 1);
    localparam logic [7:0]  CMD_RUN = 8'h02, CMD_PM = 8'h04, CMD_DM = 8'h08, CMD_RD = 8'h10;
    localparam logic [7:0]  ACK_BYTE = 8'hAA;

    typedef enum logic [3:0] {
        IDLE, GET_DATA, GET_ADDR, WRITE, RUN, RD_REQ, RD_WAIT, SEND, SEND_WAIT, DONE_ACK
    } state_t;

    state_t            state, state_next;
    logic [7:0]        cmd;
    logic [2:0]        cnt;
    logic [15:0]       cyc;
    logic [AW8-1:0]    addr_full, addr_upd;
    logic [DATA_W-1:0] rd_sh;

    function automatic logic [DATA_W-1:0] put_data(input logic [DATA_W-1:0] w,
                                                   input logic [2:0] k, input logic [7:0] b);
        int sh;
        sh = 8 * int'(k);
        return (w & ~(DATA_W'(8'hFF) << sh)) | (DATA_W'(b) << sh);
    endfunction

    function automatic logic [AW8-1:0] put_addr(input logic [AW8-1:0] w,
                                                input logic [2:0] k, input logic [7:0] b);
        int sh;
        sh = 8 * int'(k);
        return (w & ~(AW8'(8'hFF) << sh)) | (AW8'(b) << sh);
    endfunction

    assign addr_upd = put_addr(addr_full, cnt, rx_data);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:
                if (rx_done) begin
                    case (rx_data)
                        CMD_PM, CMD_DM: state_next = GET_DATA;
                        CMD_RD:         state_next = GET_ADDR;
                        CMD_RUN:        state_next = RUN;
                        default:        state_next = IDLE;
                    endcase
                end
            GET_DATA:  if (rx_done && cnt == NB_LAST) state_next = GET_ADDR;
            GET_ADDR:  if (rx_done && cnt == NA_LAST) state_next = (cmd == CMD_RD) ? RD_REQ : WRITE;
            WRITE:     state_next = IDLE;
            RUN:       if (cyc == CYC_LAST) state_next = DONE_ACK;
            RD_REQ:    state_next = RD_WAIT;
            RD_WAIT:   state_next = SEND;
            SEND:      state_next = SEND_WAIT;
            SEND_WAIT: if (tx_done) state_next = (cnt == NB_LAST) ? IDLE : SEND;
            DONE_ACK:  if (tx_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Every output is a register loaded from the next state, so strobes line up with their state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd       <= 8'h00;
            cnt       <= 3'd0;
            cyc       <= 16'd0;
            addr_full <= '0;
            rd_sh     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            wr_pm     <= 1'b0;
            wr_dm     <= 1'b0;
            rd_dm     <= 1'b0;
            cpu_en    <= 1'b0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            wr_pm     <= (state_next == WRITE) && (cmd == CMD_PM);
            wr_dm     <= (state_next == WRITE) && (cmd == CMD_DM);
            rd_dm     <= (state_next == RD_REQ);
            cpu_en    <= (state_next == RUN);
            cpu_reset <= !((state_next == RUN) || (state_next == DONE_ACK));
            busy      <= (state_next != IDLE);
            tx_start  <= (state_next == SEND) || ((state == RUN) && (state_next == DONE_ACK));
            case (state)
                IDLE:
                    if (rx_done && (rx_data == CMD_PM || rx_data == CMD_DM ||
                                    rx_data == CMD_RD || rx_data == CMD_RUN)) begin
                        cmd <= rx_data;
                        cnt <= 3'd0;
                        cyc <= 16'd0;
                    end
                GET_DATA:
                    if (rx_done) begin
                        mem_wdata <= put_data(mem_wdata, cnt, rx_data);
                        cnt       <= (cnt == NB_LAST) ? 3'd0 : cnt + 3'd1;
                    end
                GET_ADDR:
                    if (rx_done) begin
                        addr_full <= addr_upd;
                        mem_addr  <= addr_upd[ADDR_W-1:0];
                        cnt       <= (cnt == NA_LAST) ? 3'd0 : cnt + 3'd1;
                    end
                RUN: begin
                    cyc <= cyc + 16'd1;
                    if (cyc == CYC_LAST) tx_data <= ACK_BYTE;
                end
                RD_WAIT: begin
                    rd_sh   <= mem_rdata;
                    tx_data <= mem_rdata[7:0];
                    cnt     <= 3'd0;
                end
                SEND_WAIT:
                    if (tx_done && cnt != NB_LAST) begin
                        cnt     <= cnt + 3'd1;
                        rd_sh   <= rd_sh >> 8;
                        tx_data <= 8'(rd_sh >> 8);
                    end
                default: ;
            endcase
        end
    end
endmodule
